// File: rtl/race_game.sv
// race_game: N-player click-race controller. Rising edges on each player's
// click input accumulate clicks; every max_clicks clicks advance that player
// one step; the first player to reach max_steps wins, simultaneous finishers tie.
module race_game #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned PID_W       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       max_clicks,
  input  logic [CNT_W-1:0]       max_steps,
  input  logic [NUM_PLAYERS-1:0] click,
  output logic [PID_W-1:0]       output_player,
  output logic [CNT_W-1:0]       position,
  output logic [3:0]             status_code,
  output logic                   winner_valid
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_WIN     = 3'd2,
    ST_TIE     = 3'd3,
    ST_CFG_ERR = 3'd4
  } state_t;

  localparam logic [3:0] STATUS_IDLE    = 4'd0;
  localparam logic [3:0] STATUS_PLAY    = 4'd1;
  localparam logic [3:0] STATUS_WIN     = 4'd2;
  localparam logic [3:0] STATUS_TIE     = 4'd3;
  localparam logic [3:0] STATUS_CFG_ERR = 4'd4;

  state_t                              state_q, state_d;
  logic [CNT_W-1:0]                    max_clicks_q, max_clicks_d;
  logic [CNT_W-1:0]                    max_steps_q, max_steps_d;
  logic [NUM_PLAYERS-1:0][CNT_W-1:0]   clicks_q, clicks_d;
  logic [NUM_PLAYERS-1:0][CNT_W-1:0]   steps_q, steps_d;
  logic [NUM_PLAYERS-1:0]              click_prev_q, click_prev_d;
  logic [PID_W-1:0]                    output_player_q, output_player_d;
  logic [CNT_W-1:0]                    position_q, position_d;
  logic [3:0]                          status_code_q, status_code_d;
  logic                                winner_valid_q, winner_valid_d;

  logic [NUM_PLAYERS-1:0]              edge_c;
  logic                                any_fin_c;
  logic                                multi_fin_c;
  logic [PID_W-1:0]                    lead_idx_c;
  logic [CNT_W-1:0]                    lead_steps_c;

  assign edge_c = click & ~click_prev_q;

  // Register all state, counters, click history and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      max_clicks_q    <= '0;
      max_steps_q     <= '0;
      clicks_q        <= '0;
      steps_q         <= '0;
      click_prev_q    <= '0;
      output_player_q <= '0;
      position_q      <= '0;
      status_code_q   <= STATUS_IDLE;
      winner_valid_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      max_clicks_q    <= max_clicks_d;
      max_steps_q     <= max_steps_d;
      clicks_q        <= clicks_d;
      steps_q         <= steps_d;
      click_prev_q    <= click_prev_d;
      output_player_q <= output_player_d;
      position_q      <= position_d;
      status_code_q   <= status_code_d;
      winner_valid_q  <= winner_valid_d;
    end
  end

  // Next state: round start/restart, per-player counting and finish detection.
  always_comb begin
    state_d      = state_q;
    max_clicks_d = max_clicks_q;
    max_steps_d  = max_steps_q;
    clicks_d     = clicks_q;
    steps_d      = steps_q;
    click_prev_d = click;
    any_fin_c    = 1'b0;
    multi_fin_c  = 1'b0;
    if (start) begin
      max_clicks_d = max_clicks;
      max_steps_d  = max_steps;
      clicks_d     = '0;
      steps_d      = '0;
      if ((max_clicks == '0) || (max_steps == '0)) begin
        state_d = ST_CFG_ERR;
      end else begin
        state_d = ST_PLAY;
      end
    end else if (state_q == ST_PLAY) begin
      for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
        if (edge_c[i]) begin
          if (clicks_q[i] == (max_clicks_q - CNT_W'(1))) begin
            clicks_d[i] = '0;
            steps_d[i]  = steps_q[i] + CNT_W'(1);
          end else begin
            clicks_d[i] = clicks_q[i] + CNT_W'(1);
          end
        end
      end
      for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
        if (steps_d[i] == max_steps_q) begin
          if (any_fin_c) begin
            multi_fin_c = 1'b1;
          end
          any_fin_c = 1'b1;
        end
      end
      if (multi_fin_c) begin
        state_d = ST_TIE;
      end else if (any_fin_c) begin
        state_d = ST_WIN;
      end
    end
  end

  // Leader: highest step count, lowest index on equal steps. Once a round has
  // finished, counting is frozen and the finishers hold max_steps, so the same
  // search yields the winner (WIN) or lowest finishing index (TIE).
  always_comb begin
    lead_idx_c   = '0;
    lead_steps_c = steps_q[0];
    for (int i = 1; i < int'(NUM_PLAYERS); i++) begin
      if (steps_q[i] > lead_steps_c) begin
        lead_idx_c   = PID_W'(i);
        lead_steps_c = steps_q[i];
      end
    end
  end

  // Output decode from the registered state, registered one cycle later.
  always_comb begin
    output_player_d = '0;
    position_d      = '0;
    status_code_d   = STATUS_IDLE;
    winner_valid_d  = 1'b0;
    case (state_q)
      ST_PLAY: begin
        output_player_d = lead_idx_c;
        position_d      = lead_steps_c;
        status_code_d   = STATUS_PLAY;
      end
      ST_WIN: begin
        output_player_d = lead_idx_c;
        position_d      = lead_steps_c;
        status_code_d   = STATUS_WIN;
        winner_valid_d  = 1'b1;
      end
      ST_TIE: begin
        output_player_d = lead_idx_c;
        position_d      = lead_steps_c;
        status_code_d   = STATUS_TIE;
      end
      ST_CFG_ERR: begin
        status_code_d   = STATUS_CFG_ERR;
      end
      default: begin
        status_code_d   = STATUS_IDLE;
      end
    endcase
  end

  assign output_player = output_player_q;
  assign position      = position_q;
  assign status_code   = status_code_q;
  assign winner_valid  = winner_valid_q;

endmodule

// File: tb/tb_race_game.sv
// Bench for race_game: a 4-player and an 8-player instance, checked cycle by
// cycle against a model that tracks total clicks per player and derives steps
// by division.
module tb_race_game;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start4 = 1'b0;
  logic       start8 = 1'b0;
  logic [3:0] mc = 4'd0;
  logic [3:0] ms = 4'd0;
  logic [3:0] click4 = '0;
  logic [7:0] click8 = '0;

  logic [1:0] op4;
  logic [3:0] pos4;
  logic [3:0] sc4;
  logic       wv4;
  logic [2:0] op8;
  logic [3:0] pos8;
  logic [3:0] sc8;
  logic       wv8;

  int n_checks = 0;
  int n_pass   = 0;
  bit sel8     = 1'b0;

  // Model: phase 0 idle, 1 play, 2 win, 3 tie, 4 cfg error.
  int          m_phase;
  int          m_mc;
  int          m_ms;
  int          tot [16];
  logic [15:0] m_prev;

  always #5 clk = ~clk;

  race_game #(.NUM_PLAYERS(4), .CNT_W(4), .PID_W(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .max_clicks(mc), .max_steps(ms),
    .click(click4), .output_player(op4), .position(pos4),
    .status_code(sc4), .winner_valid(wv4)
  );

  race_game #(.NUM_PLAYERS(8), .CNT_W(4), .PID_W(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .max_clicks(mc), .max_steps(ms),
    .click(click8), .output_player(op8), .position(pos8),
    .status_code(sc8), .winner_valid(wv8)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int num_players();
    return sel8 ? 8 : 4;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_mc    = 0;
    m_ms    = 0;
    m_prev  = '0;
    for (int i = 0; i < 16; i++) tot[i] = 0;
  endtask

  task automatic model_outputs(output int e_op, output int e_pos, output int e_sc, output int e_wv);
    int best;
    int s;
    e_op = 0; e_pos = 0; e_sc = m_phase; e_wv = (m_phase == 2) ? 1 : 0;
    if (m_phase >= 1 && m_phase <= 3) begin
      best = -1;
      for (int i = 0; i < num_players(); i++) begin
        s = tot[i] / m_mc;
        if (s > best) begin
          best = s;
          e_op = i;
        end
      end
      e_pos = best;
    end
  endtask

  task automatic model_update(input bit st, input logic [15:0] c);
    int nf;
    if (st) begin
      m_mc = int'(mc);
      m_ms = int'(ms);
      for (int i = 0; i < 16; i++) tot[i] = 0;
      m_phase = (m_mc == 0 || m_ms == 0) ? 4 : 1;
    end else if (m_phase == 1) begin
      for (int i = 0; i < num_players(); i++)
        if (c[i] && !m_prev[i]) tot[i]++;
      nf = 0;
      for (int i = 0; i < num_players(); i++)
        if (tot[i] / m_mc >= m_ms) nf++;
      if (nf == 1) m_phase = 2;
      else if (nf > 1) m_phase = 3;
    end
    m_prev = c;
  endtask

  function automatic int got_op();  return sel8 ? int'(op8)  : int'(op4);  endfunction
  function automatic int got_pos(); return sel8 ? int'(pos8) : int'(pos4); endfunction
  function automatic int got_sc();  return sel8 ? int'(sc8)  : int'(sc4);  endfunction
  function automatic int got_wv();  return sel8 ? int'(wv8)  : int'(wv4);  endfunction

  // One clock: drive inputs, let the edge happen, compare outputs to the model.
  task automatic tick(input bit st, input logic [15:0] c);
    int e_op, e_pos, e_sc, e_wv;
    logic [15:0] cm;
    cm = sel8 ? (c & 16'h00ff) : (c & 16'h000f);
    if (sel8) begin
      start8 = st; click8 = cm[7:0]; start4 = 1'b0; click4 = '0;
    end else begin
      start4 = st; click4 = cm[3:0]; start8 = 1'b0; click8 = '0;
    end
    @(posedge clk);
    model_outputs(e_op, e_pos, e_sc, e_wv);
    model_update(st, cm);
    #1;
    check("player", got_op(), e_op);
    check("position", got_pos(), e_pos);
    check("status", got_sc(), e_sc);
    check("winner_valid", got_wv(), e_wv);
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    start4 = 1'b0; start8 = 1'b0; click4 = '0; click8 = '0;
    rst = 1'b1;
    #1;
    check("rst_player", got_op(), 0);
    check("rst_position", got_pos(), 0);
    check("rst_status", got_sc(), 0);
    check("rst_winner_valid", got_wv(), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pulses(input logic [15:0] c, input int n);
    for (int k = 0; k < n; k++) begin
      tick(1'b0, c);
      tick(1'b0, 16'h0);
    end
  endtask

  task automatic random_rounds(input int rounds);
    logic [15:0] c;
    for (int r = 0; r < rounds; r++) begin
      mc = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
      ms = 4'($urandom_range(1, 4));
      tick(1'b1, 16'h0);
      for (int k = 0; k < 60; k++) begin
        c = 16'($urandom);
        if ($urandom_range(0, 49) == 0) begin
          mc = 4'($urandom_range(1, 3));
          tick(1'b1, c);
        end else begin
          tick(1'b0, c);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    // Spec case: 3 clicks per step, 2 steps, player 1 clicks six times.
    mc = 4'd3; ms = 4'd2;
    tick(1'b1, 16'h0);
    pulses(16'h2, 3);
    tick(1'b0, 16'h0);
    check("p1_step1_position", int'(pos4), 1);
    pulses(16'h2, 3);
    tick(1'b0, 16'h0);
    check("p1_win_status", int'(sc4), 2);
    check("p1_win_player", int'(op4), 1);
    check("p1_win_valid", int'(wv4), 1);

    // Spec case: players 0 and 2 finish on the same edge.
    mc = 4'd1; ms = 4'd4;
    tick(1'b1, 16'h0);
    pulses(16'h5, 4);
    tick(1'b0, 16'h0);
    check("tie_status", int'(sc4), 3);
    check("tie_player", int'(op4), 0);
    check("tie_position", int'(pos4), 4);

    // Held button counts once.
    mc = 4'd1; ms = 4'd4;
    tick(1'b1, 16'h0);
    for (int k = 0; k < 50; k++) tick(1'b0, 16'h1);
    tick(1'b0, 16'h0);
    check("held_position", int'(pos4), 1);
    check("held_status", int'(sc4), 1);

    // Button already high at start is not counted.
    tick(1'b1, 16'h8);
    tick(1'b0, 16'h8);
    tick(1'b0, 16'h0);
    check("prehigh_position", int'(pos4), 0);

    // Zero configuration is an error; clicks ignored; then a good start.
    mc = 4'd0; ms = 4'd3;
    tick(1'b1, 16'h0);
    pulses(16'hf, 3);
    check("cfg_err_status", int'(sc4), 4);
    mc = 4'd2; ms = 4'd2;
    tick(1'b1, 16'h0);
    tick(1'b0, 16'h0);
    check("restart_status", int'(sc4), 1);
    check("restart_position", int'(pos4), 0);

    // Reset in the middle of a round after player 3 reaches step 3.
    mc = 4'd1; ms = 4'd5;
    tick(1'b1, 16'h0);
    pulses(16'h8, 3);
    tick(1'b0, 16'h0);
    check("mid_player", int'(op4), 3);
    check("mid_position", int'(pos4), 3);
    do_reset();
    tick(1'b0, 16'h0);
    check("post_rst_status", int'(sc4), 0);

    random_rounds(20);

    // Eight players: player 6 and 7 level, leader stays 6 until 7 is ahead.
    sel8 = 1'b1;
    do_reset();
    mc = 4'd2; ms = 4'd3;
    tick(1'b1, 16'h0);
    pulses(16'h40, 4);
    pulses(16'h80, 4);
    tick(1'b0, 16'h0);
    check("p8_level_player", int'(op8), 6);
    check("p8_level_position", int'(pos8), 2);
    pulses(16'h80, 1);
    tick(1'b0, 16'h0);
    check("p8_half_player", int'(op8), 6);
    pulses(16'h80, 1);
    tick(1'b0, 16'h0);
    check("p8_win_player", int'(op8), 7);
    check("p8_win_status", int'(sc8), 2);
    check("p8_win_position", int'(pos8), 3);

    random_rounds(15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
